// File: rtl/nios2_dbg_pkg.sv
// Shared encodings for the Nios II debug command sequencer.
package nios2_dbg_pkg;

  // Command word width and field positions within jdo
  localparam int unsigned JDO_W      = 38;
  localparam int unsigned JDO_SUB_HI = 37;
  localparam int unsigned JDO_SUB_LO = 36;
  localparam int unsigned JDO_IDX_HI = 35;
  localparam int unsigned JDO_IDX_LO = 34;
  localparam int unsigned JDO_DAT_HI = 31;
  localparam int unsigned JDO_DAT_LO = 0;
  localparam int unsigned JDO_TRC_HI = 15;
  localparam int unsigned JDO_TRC_LO = 0;
  localparam int unsigned TRC_W      = 16;

  // Instruction register classes
  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE  = 2'b01;
  localparam logic [1:0] IR_BREAK  = 2'b10;
  localparam logic [1:0] IR_RSVD   = 2'b11;

  // ocimem subcommands in jdo[37:36]
  localparam logic [1:0] SUB_SETADDR = 2'b00;
  localparam logic [1:0] SUB_WRITE   = 2'b01;
  localparam logic [1:0] SUB_READ    = 2'b10;
  localparam logic [1:0] SUB_NOP     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/nios2_debug_cmd_sequencer.sv
// Debug command sequencer: decodes JTAG debug commands and drives the on-chip
// debug memory, break registers and trace control. Optional access timeout is
// enabled by defining DBG_SEQ_TIMEOUT_EN.
module nios2_debug_cmd_sequencer
  import nios2_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [1:0]          ir_in,
  input  logic [JDO_W-1:0]    jdo,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                brk_wr,
  output logic [1:0]          brk_idx,
  output logic [DATA_W-1:0]   brk_data,
  output logic                trc_wr,
  output logic [TRC_W-1:0]    trc_data,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                mem_rd_nxt, mem_wr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                brk_wr_nxt;
  logic [1:0]          brk_idx_nxt;
  logic [DATA_W-1:0]   brk_data_nxt;
  logic                trc_wr_nxt;
  logic [TRC_W-1:0]    trc_data_nxt;
  logic [DATA_W-1:0]   mon_dreg_nxt;
  logic                ready_nxt, error_nxt;

  // jdo[33:32] carry no meaning for any command
  logic unused_jdo;
  assign unused_jdo = ^jdo[33:32];

`ifdef DBG_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`else
  localparam int unsigned UNUSED_MAX_WAIT = MAX_WAIT;
`endif

  // Next-state and next-value decode for every registered output
  always_comb begin
    state_nxt     = state;
    addr_nxt      = mem_addr;
    mem_rd_nxt    = mem_rd;
    mem_wr_nxt    = mem_wr;
    mem_wdata_nxt = mem_wdata;
    brk_wr_nxt    = 1'b0;
    brk_idx_nxt   = brk_idx;
    brk_data_nxt  = brk_data;
    trc_wr_nxt    = 1'b0;
    trc_data_nxt  = trc_data;
    mon_dreg_nxt  = MonDReg;
    ready_nxt     = monitor_ready;
    error_nxt     = monitor_error;
`ifdef DBG_SEQ_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          ready_nxt = 1'b0;
          state_nxt = ST_DONE;
          case (ir_in)
            IR_OCIMEM: begin
              case (jdo[JDO_SUB_HI:JDO_SUB_LO])
                SUB_SETADDR: begin
                  addr_nxt  = jdo[ADDR_W-1:0];
                  error_nxt = 1'b0;
                end
                SUB_WRITE: begin
                  mem_wdata_nxt = jdo[JDO_DAT_HI:JDO_DAT_LO];
                  mem_wr_nxt    = 1'b1;
                  state_nxt     = ST_MEM;
                end
                SUB_READ: begin
                  mem_rd_nxt = 1'b1;
                  state_nxt  = ST_MEM;
                end
                default: ;
              endcase
`ifdef DBG_SEQ_TIMEOUT_EN
              wait_cnt_nxt = '0;
`endif
            end
            IR_TRACE: begin
              trc_wr_nxt   = 1'b1;
              trc_data_nxt = jdo[JDO_TRC_HI:JDO_TRC_LO];
            end
            IR_BREAK: begin
              brk_wr_nxt   = 1'b1;
              brk_idx_nxt  = jdo[JDO_IDX_HI:JDO_IDX_LO];
              brk_data_nxt = jdo[JDO_DAT_HI:JDO_DAT_LO];
            end
            default: error_nxt = 1'b1;
          endcase
        end
      end

      ST_MEM: begin
        if (cmd_valid) error_nxt = 1'b1;
        if (mem_ack) begin
          if (mem_rd) mon_dreg_nxt = mem_rdata;
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          addr_nxt   = mem_addr + ADDR_W'(1);
          state_nxt  = ST_DONE;
        end
`ifdef DBG_SEQ_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          error_nxt  = 1'b1;
          state_nxt  = ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
`endif
      end

      ST_DONE: begin
        if (cmd_valid) error_nxt = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      mem_wdata     <= '0;
      brk_wr        <= 1'b0;
      brk_idx       <= '0;
      brk_data      <= '0;
      trc_wr        <= 1'b0;
      trc_data      <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
`ifdef DBG_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state         <= state_nxt;
      mem_addr      <= addr_nxt;
      mem_rd        <= mem_rd_nxt;
      mem_wr        <= mem_wr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      brk_wr        <= brk_wr_nxt;
      brk_idx       <= brk_idx_nxt;
      brk_data      <= brk_data_nxt;
      trc_wr        <= trc_wr_nxt;
      trc_data      <= trc_data_nxt;
      MonDReg       <= mon_dreg_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= error_nxt;
`ifdef DBG_SEQ_TIMEOUT_EN
      wait_cnt      <= wait_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_nios2_debug_cmd_sequencer.sv
// Directed self-checking bench for nios2_debug_cmd_sequencer.
module tb_nios2_debug_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  ir_in;
  logic [37:0] jdo;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        brk_wr;
  logic [1:0]  brk_idx;
  logic [31:0] brk_data;
  logic        trc_wr;
  logic [15:0] trc_data;
  logic [31:0] mon_dreg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int failures = 0;

  nios2_debug_cmd_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .ir_in(ir_in), .jdo(jdo),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .brk_wr(brk_wr), .brk_idx(brk_idx),
    .brk_data(brk_data), .trc_wr(trc_wr), .trc_data(trc_data), .MonDReg(mon_dreg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one cycle
  task automatic send(input logic [1:0] ir, input logic [37:0] word);
    cmd_valid = 1'b1;
    ir_in     = ir;
    jdo       = word;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Hold the request for lat cycles, acking in the last one
  task automatic mem_access(input int lat, input logic [31:0] rdata, input string tag);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_req_held"}, 64'(mem_rd | mem_wr), 64'd1);
      if (i == lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, 64'(mem_rd | mem_wr), 64'd0);
  endtask

  function automatic logic [37:0] ocimem(input logic [1:0] sub, input logic [31:0] d);
    return {sub, 4'b0000, d};
  endfunction

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; ir_in = 2'b00; jdo = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_ready", 64'(monitor_ready), 64'd1);
    chk("rst_error", 64'(monitor_error), 64'd0);
    chk("rst_memreq", 64'({mem_rd, mem_wr, brk_wr, trc_wr}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_mondreg", 64'(mon_dreg), 64'd0);

    // Set address, write, read with 3-cycle memory latency
    send(2'b00, ocimem(2'b00, 32'h010));
    chk("sa_ready_low", 64'(monitor_ready), 64'd0);
    chk("sa_addr", 64'(mem_addr), 64'h010);
    tick();
    chk("sa_ready_high", 64'(monitor_ready), 64'd1);

    send(2'b00, ocimem(2'b01, 32'hDEADBEEF));
    chk("wr_mem_wr", 64'(mem_wr), 64'd1);
    chk("wr_addr", 64'(mem_addr), 64'h010);
    chk("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("wr_ready_low", 64'(monitor_ready), 64'd0);
    mem_access(3, 32'h0, "wr");
    chk("wr_addr_inc", 64'(mem_addr), 64'h011);
    tick();
    chk("wr_ready_high", 64'(monitor_ready), 64'd1);

    send(2'b00, ocimem(2'b10, 32'h0));
    chk("rd_mem_rd", 64'(mem_rd), 64'd1);
    chk("rd_addr", 64'(mem_addr), 64'h011);
    mem_access(3, 32'h12345678, "rd");
    chk("rd_mondreg", 64'(mon_dreg), 64'h12345678);
    chk("rd_addr_inc", 64'(mem_addr), 64'h012);
    tick();
    chk("rd_ready_high", 64'(monitor_ready), 64'd1);

    // Address wrap with minimum-latency ack
    send(2'b00, ocimem(2'b00, 32'h1FF));
    tick();
    send(2'b00, ocimem(2'b01, 32'h1));
    chk("wrap_w1_addr", 64'(mem_addr), 64'h1FF);
    mem_access(1, 32'h0, "wrap_w1");
    chk("wrap_w1_ready_low", 64'(monitor_ready), 64'd0);
    tick();
    chk("wrap_w1_ready", 64'(monitor_ready), 64'd1);
    send(2'b00, ocimem(2'b01, 32'h2));
    chk("wrap_w2_addr", 64'(mem_addr), 64'h000);
    chk("wrap_w2_wdata", 64'(mem_wdata), 64'h2);
    mem_access(1, 32'h0, "wrap_w2");
    tick();
    chk("wrap_addr_after", 64'(mem_addr), 64'h001);

    // Break register write
    send(2'b10, {2'b00, 2'b10, 2'b00, 32'hA5A5A5A5});
    chk("brk_wr", 64'(brk_wr), 64'd1);
    chk("brk_idx", 64'(brk_idx), 64'd2);
    chk("brk_data", 64'(brk_data), 64'hA5A5A5A5);
    chk("brk_no_mem", 64'({mem_rd, mem_wr}), 64'd0);
    tick();
    chk("brk_pulse_end", 64'(brk_wr), 64'd0);
    chk("brk_ready", 64'(monitor_ready), 64'd1);

    // Trace control write
    send(2'b01, {22'd0, 16'hBEEF});
    chk("trc_wr", 64'(trc_wr), 64'd1);
    chk("trc_data", 64'(trc_data), 64'hBEEF);
    tick();
    chk("trc_pulse_end", 64'(trc_wr), 64'd0);

    // Command arriving mid-read is dropped and flags an error
    send(2'b00, ocimem(2'b10, 32'h0));
    chk("busy_rd", 64'(mem_rd), 64'd1);
    send(2'b10, {2'b00, 2'b01, 2'b00, 32'h11111111});
    chk("busy_error", 64'(monitor_error), 64'd1);
    chk("busy_no_brk", 64'(brk_wr), 64'd0);
    mem_access(2, 32'hCAFEF00D, "busy");
    chk("busy_mondreg", 64'(mon_dreg), 64'hCAFEF00D);
    chk("busy_addr_inc", 64'(mem_addr), 64'h002);
    tick();
    chk("busy_error_sticky", 64'(monitor_error), 64'd1);
    send(2'b00, ocimem(2'b00, 32'h005));
    chk("sa_clears_error", 64'(monitor_error), 64'd0);
    tick();

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("stray_ack_mondreg", 64'(mon_dreg), 64'hCAFEF00D);
    chk("stray_ack_addr", 64'(mem_addr), 64'h005);

    // Reserved IR
    send(2'b11, 38'd0);
    chk("rsvd_error", 64'(monitor_error), 64'd1);
    tick();

`ifdef DBG_SEQ_TIMEOUT_EN
    // Read that is never acked times out
    begin
      int n;
      send(2'b00, ocimem(2'b00, 32'h005));
      tick();
      send(2'b00, ocimem(2'b10, 32'h0));
      n = 0;
      while (mem_rd && n < 40) begin
        n++;
        tick();
      end
      chk("to_cycles", 64'(n), 64'd15);
      chk("to_error", 64'(monitor_error), 64'd1);
      chk("to_addr", 64'(mem_addr), 64'h005);
      chk("to_mondreg", 64'(mon_dreg), 64'hCAFEF00D);
      tick();
      chk("to_ready", 64'(monitor_ready), 64'd1);
    end
`endif

    // Reset during a pending write (error still set from reserved command)
    send(2'b00, ocimem(2'b01, 32'h77));
    chk("rstmid_wr", 64'(mem_wr), 64'd1);
    chk("rstmid_err_before", 64'(monitor_error), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_wr_drop", 64'(mem_wr), 64'd0);
    chk("rstmid_ready", 64'(monitor_ready), 64'd1);
    chk("rstmid_error", 64'(monitor_error), 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_mondreg", 64'(mon_dreg), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_debug_cmd_sequencer.md
Name: nios2_debug_cmd_sequencer

Overview:
- Sits in the CPU clock domain behind the debug slave's synchronised update-DR strobe.
- Decodes each 38-bit debug command word by its 2-bit IR and sequences it onto the on-chip debug memory, break-register and trace-control resources.
- Owns the auto-incrementing debug memory address, the read-back data register (MonDReg) and the monitor_ready/monitor_error status returned to the JTAG host.

Parameters:
- ADDR_W, 9, debug memory word-address width.
- DATA_W, 32, data width of memory and break/trace writes.
- MAX_WAIT, 15, maximum cycles spent waiting on mem_ack before the access is abandoned.

Ports:
- clk  in  1  CPU clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  one-cycle pulse: synchronised update-DR, command present.
- ir_in  in  2  command class: 00 ocimem, 01 trace ctrl, 10 break, 11 reserved.
- jdo  in  38  command word.
- mem_addr  out  ADDR_W  debug memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- brk_wr  out  1  one-cycle break-register write strobe.
- brk_idx  out  2  break register index.
- brk_data  out  DATA_W  break write data.
- trc_wr  out  1  one-cycle trace-control write strobe.
- trc_data  out  16  trace-control word.
- MonDReg  out  DATA_W  last read data.
- monitor_ready  out  1  sequencer idle, last command complete.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, except monitor_ready=1. Address register = 0. State = IDLE.
- States:
  - IDLE: accepts cmd_valid.
  - MEM: asserts mem_rd or mem_wr and holds it until mem_ack.
  - DONE: one cycle; updates status, then returns to IDLE.
- ir=00, subcommand jdo[37:36]:
  - 00 set address: addr=jdo[ADDR_W-1:0] and clears monitor_error. Goes IDLE->DONE.
  - 01 write: mem_wdata=jdo[31:0]. Goes IDLE->MEM with mem_wr=1 from the next cycle.
  - 10 read: goes IDLE->MEM with mem_rd=1. On mem_ack, MonDReg<=mem_rdata.
  - 11: no-op, IDLE->DONE.
- MEM handshake: mem_rd/mem_wr stay asserted and mem_addr/mem_wdata stay stable until mem_ack is sampled high. The request deasserts the following cycle and the state goes to DONE. mem_ack in the same cycle the request first asserts is legal, giving minimum latency cmd_valid -> DONE of 2 cycles.
- Auto-increment: after every acked read or write, addr<=addr+1, wrapping from 2^ADDR_W-1 to 0.
- ir=10: in the cycle after cmd_valid, brk_wr=1 for exactly one cycle with brk_idx=jdo[35:34] and brk_data=jdo[31:0]. Then DONE.
- ir=01: same pattern with trc_wr, trc_data=jdo[15:0]. Then DONE.
- ir=11: reserved. Sets monitor_error, then DONE.
- monitor_ready drops in the cycle after an accepted cmd_valid and rises in DONE.
- cmd_valid outside IDLE: the command is dropped, monitor_error is set, and the in-flight operation continues unaffected.
- mem_ack outside MEM: ignored.
- Reset mid-access: the request drops on the next cycle. No address increment and no MonDReg update.
- monitor_error clears only on reset or a set-address command.

Optional Feature:
- DBG_SEQ_TIMEOUT_EN defined: MEM holds a wait counter that clears on MEM entry. When the counter reaches MAX_WAIT without mem_ack, the request drops, monitor_error is set, the address does not increment, MonDReg is unchanged, and the state goes to DONE.
- DBG_SEQ_TIMEOUT_EN undefined: no counter exists; MEM waits indefinitely for mem_ack.

Decomposition:
- Shared package nios2_dbg_pkg holds:
  - the IR encodings (IR_OCIMEM, IR_TRACE, IR_BREAK, IR_RSVD);
  - the ocimem subcommand encodings;
  - the state enum;
  - the jdo field bit positions.
- No sub-module. The address/auto-increment and timeout counters are small enough to stay inline.

Test Plan:
- Set address 0x010, write 0xDEADBEEF, read, with a mem model acking after 3 cycles -> mem_addr 0x010 on write; the read targets 0x011; monitor_ready returns 1 after each command.
- Set address 0x1FF, write 0x1, write 0x2 -> writes land at 0x1FF then 0x000 (wrap).
- Break command with ir=10, jdo[35:34]=2, data 0xA5A5A5A5 -> single-cycle brk_wr, brk_idx=2, brk_data=0xA5A5A5A5; mem_rd/mem_wr stay 0.
- cmd_valid while a read waits on mem_ack -> second command dropped, monitor_error=1; the read completes and MonDReg=mem_rdata; a subsequent set-address clears monitor_error.
- With DBG_SEQ_TIMEOUT_EN, read with no mem_ack -> request drops after 15 cycles, monitor_error=1, address unchanged, MonDReg unchanged.
- Assert reset during a pending write -> next cycle mem_wr=0, monitor_ready=1, monitor_error=0, address=0.
